// File: rtl/formula_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : formula_sweep_ctrl
// Purpose  : Walks every universal-input assignment through a shared formula
//            evaluator, counts failures and latches the first counterexample.
// Revision : 1.0  initial release
// ============================================================================
module formula_sweep_ctrl #(
    parameter int N_I          = 9,
    parameter int N_X          = 4,
    parameter int EVAL_LAT     = 1,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [N_I-1:0]   i_vec,
    input  logic             eval_out,
    input  logic [N_X-1:0]   x_vec,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             aborted,
    output logic [N_I:0]     fail_count,
    output logic             cex_valid,
    output logic [N_I-1:0]   cex_i,
    output logic [N_X-1:0]   cex_x
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam logic [3:0]     c_lat      = 4'(EVAL_LAT);
    localparam logic [N_I-1:0] c_all_ones = '1;
    localparam logic [N_I-1:0] c_i_one    = N_I'(1);
    localparam logic [N_I:0]   c_fc_one   = (N_I+1)'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    state_t            w_first;
    logic [3:0]        r_settle_cnt;
    logic [N_I-1:0]    r_i_vec;
    logic              r_pass;
    logic              r_aborted;
    logic [N_I:0]      r_fail_count;
    logic              r_cex_valid;
    logic [N_I-1:0]    r_cex_i;
    logic [N_X-1:0]    r_cex_x;

    logic              w_sample;
    logic              w_fail;
    logic              w_stop;

    // With no settle latency each assignment is a single SAMPLE cycle.
    assign w_first  = (EVAL_LAT == 0) ? S_SAMPLE : S_SETTLE;
    assign w_sample = (r_state == S_SAMPLE) && !abort;
    assign w_fail   = w_sample && !eval_out;
    assign w_stop   = (r_i_vec == c_all_ones) || ((STOP_ON_FAIL != 0) && w_fail);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = w_first;
            S_SETTLE: begin
                if (abort)                   w_state_nxt = S_FINISH;
                else if (r_settle_cnt <= 4'd1) w_state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (abort || w_stop) w_state_nxt = S_FINISH;
                else                 w_state_nxt = w_first;
            end
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle_cnt <= '0;
            r_i_vec      <= '0;
            r_pass       <= 1'b0;
            r_aborted    <= 1'b0;
            r_fail_count <= '0;
            r_cex_valid  <= 1'b0;
            r_cex_i      <= '0;
            r_cex_x      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_i_vec      <= '0;
                        r_settle_cnt <= c_lat;
                        r_pass       <= 1'b0;
                        r_aborted    <= 1'b0;
                        r_fail_count <= '0;
                        r_cex_valid  <= 1'b0;
                        r_cex_i      <= '0;
                        r_cex_x      <= '0;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        r_aborted <= 1'b1;
                        r_pass    <= 1'b0;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    if (abort) begin
                        r_aborted <= 1'b1;
                        r_pass    <= 1'b0;
                    end else begin
                        if (w_fail) begin
                            r_fail_count <= r_fail_count + c_fc_one;
                            if (!r_cex_valid) begin
                                r_cex_valid <= 1'b1;
                                r_cex_i     <= r_i_vec;
                                r_cex_x     <= x_vec;
                            end
                        end
                        // Verdict is registered on entry to FINISH so it is valid alongside done.
                        if (w_stop) begin
                            r_pass <= (r_fail_count == '0) && !w_fail;
                        end else begin
                            r_i_vec      <= r_i_vec + c_i_one;
                            r_settle_cnt <= c_lat;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign i_vec      = r_i_vec;
    assign busy       = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
    assign done       = (r_state == S_FINISH);
    assign pass       = r_pass;
    assign aborted    = r_aborted;
    assign fail_count = r_fail_count;
    assign cex_valid  = r_cex_valid;
    assign cex_i      = r_cex_i;
    assign cex_x      = r_cex_x;

endmodule
`default_nettype wire

// File: doc/formula_sweep_ctrl.md
# formula_sweep_ctrl

Sequential exhaustive-check controller for a combinational Boolean specification block. It enumerates every assignment of the specification's universal (`i_*`) inputs and drives each assignment to the shared evaluator. The evaluator is the specification plus the candidate Skolem functions that produce the `x_*` values. For each assignment the block samples the evaluator's `out` bit and the candidate `x` vector, counts failures and latches the first counterexample. It sits between the test/control interface and one instance of the formula evaluator, and is the only driver of that evaluator's `i` inputs.

## Interface
Parameters:
- `N_I`, default 9: number of universal inputs enumerated.
- `N_X`, default 4: width of the candidate `x` vector captured for counterexamples.
- `EVAL_LAT`, default 1: settle cycles between driving `i_vec` and sampling; range 0..15.
- `STOP_ON_FAIL`, default 0: 1 ends the sweep at the first failing assignment.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request; accepted only in IDLE.
- `abort`  in  1  terminates an active sweep.
- `i_vec`  out  N_I  assignment driven to the evaluator's `i_*` inputs; bit k maps to the k-th universal input.
- `eval_out`  in  1  evaluator `out` (1 = specification satisfied).
- `x_vec`  in  N_X  candidate `x` values from the Skolem functions.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse when the sweep ends (normal, stop-on-fail or abort).
- `pass`  out  1  valid from `done` until the next accepted `start`: 1 iff the sweep completed all assignments with zero failures.
- `aborted`  out  1  the last sweep ended by `abort`.
- `fail_count`  out  N_I+1  number of failing assignments; saturation is impossible.
- `cex_valid`  out  1  at least one failure has been captured.
- `cex_i`  out  N_I  first failing assignment.
- `cex_x`  out  N_X  `x_vec` sampled at the first failure.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, FINISH.
- **IDLE**, with `start`=1:
  - clear `fail_count`, `cex_*`, `pass`, `aborted`;
  - set `i_vec`=0 and `settle_cnt`=EVAL_LAT;
  - go to SETTLE, or straight to SAMPLE if EVAL_LAT=0.
- **SETTLE**: decrement `settle_cnt`; go to SAMPLE when it reaches 1.
- **SAMPLE**: evaluate `eval_out`.
  - If `eval_out`=0: increment `fail_count`. If `cex_valid`=0, also latch `cex_i`←`i_vec`, `cex_x`←`x_vec` and set `cex_valid`.
  - If `i_vec` = all-ones, or (`STOP_ON_FAIL` and a failure occurred this cycle): go to FINISH.
  - Otherwise: `i_vec`←`i_vec`+1, reload `settle_cnt`, go to SETTLE (or stay in SAMPLE if EVAL_LAT=0).
  - `i_vec` never wraps. The terminal test uses the all-ones compare, not a carry-out.
- **FINISH**:
  - assert `done` for one cycle;
  - set `pass`=(`fail_count`==0 && !`aborted`);
  - hold `i_vec` at its last value;
  - return to IDLE.
- **`abort`** in SETTLE or SAMPLE: takes priority over sampling. That cycle's sample is discarded, `aborted`←1, go to FINISH. `abort` in IDLE or FINISH is ignored.
- **`start`** outside IDLE is ignored, including in the FINISH cycle.
- **`rst_n`**=0 at any time, including mid-sweep: immediate return to IDLE. All outputs go to 0: `i_vec`, `busy`, `done`, `pass`, `aborted`, `fail_count`, `cex_*`.

## Timing
- `busy`=1 in SETTLE and SAMPLE. It rises the cycle after `start` is accepted and falls in the FINISH cycle, coincident with `done`.
- Each assignment takes exactly EVAL_LAT+1 cycles. `i_vec` is stable for all of those cycles and is sampled in the last one.
- Full sweep with no stop: `busy` high for 2^N_I × (EVAL_LAT+1) cycles. `done` occurs on the following cycle.
- `fail_count`, `cex_*` update on the clock edge ending the SAMPLE cycle. They are stable while `done` is high and afterwards.
- The evaluator is combinational, or pipelined with depth ≤ EVAL_LAT. The controller does not look at `eval_out` outside SAMPLE.

## Test plan
- N_I=3, EVAL_LAT=1, `eval_out` tied 1, `start` pulse → `i_vec` steps 0..7, 2 cycles each; `busy` high 16 cycles; `done` pulse; `pass`=1, `fail_count`=0, `cex_valid`=0.
- N_I=3, EVAL_LAT=0, `eval_out`=0 only when `i_vec`∈{5,6}, `x_vec`=`i_vec`+1 → `busy` 8 cycles; `fail_count`=2, `cex_i`=5, `cex_x`=6, `pass`=0.
- Same stimulus with STOP_ON_FAIL=1 → sweep ends after sampling `i_vec`=5; `done` on the next cycle; `fail_count`=1, final `i_vec`=5.
- `abort` asserted while `i_vec`=3 in SAMPLE with `eval_out`=0 → failure not counted; `done` next cycle; `aborted`=1, `pass`=0, `fail_count`=0.
- `start` pulsed while busy and in the FINISH cycle → ignored; a `start` in the following IDLE cycle begins a new sweep at `i_vec`=0 with counters cleared.
- `rst_n` low mid-sweep (asynchronous, between clock edges) → all outputs 0 immediately; after release the block stays in IDLE until `start`.
